// File: rtl/lin_pkg.sv
// Shared types and helpers for the streaming linear layer engine.
package lin_pkg;

  // Layer sequencing states, exposed on the debug port of the top.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    LOAD_ACT = 3'd2,
    BIAS     = 3'd3,
    MAC      = 3'd4,
    POST     = 3'd5,
    WRITE    = 3'd6,
    DONE     = 3'd7
  } state_t;

  // Largest value representable in a signed field of width w.
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/lin_postproc.sv
// Combinational post-processing of one accumulator: optional ReLU, arithmetic
// right shift, then saturation into the signed output range.
module lin_postproc
  import lin_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic                 i_relu_en,
  input  logic [4:0]           i_shift,
  output logic [OUT_WIDTH-1:0] o_result,
  output logic                 o_sat
);

  localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'(sat_hi(OUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] LO = ACC_WIDTH'(sat_lo(OUT_WIDTH));

  logic signed [ACC_WIDTH-1:0] w_relu;
  logic signed [ACC_WIDTH-1:0] w_shr;

  // ReLU first, then shift, then clip; o_sat marks a clipped result.
  always_comb begin
    w_relu = signed'(i_acc);
    if (i_relu_en && w_relu[ACC_WIDTH-1]) w_relu = '0;
    w_shr    = w_relu >>> i_shift;
    o_sat    = 1'b0;
    o_result = w_shr[OUT_WIDTH-1:0];
    if (w_shr > HI) begin
      o_result = HI[OUT_WIDTH-1:0];
      o_sat    = 1'b1;
    end else if (w_shr < LO) begin
      o_result = LO[OUT_WIDTH-1:0];
      o_sat    = 1'b1;
    end
  end

endmodule

// File: rtl/linear_layer_stream_mem.sv
// Fully-connected layer engine. Activations are buffered locally; bias and
// weights stream from the shared bus one word per granted cycle and are
// accumulated on the fly. One result word is written back per output row.
//
// Bus handshake: bus_req is raised from REQ until DONE. A bus cycle happens
// only in a cycle where the FSM is in a bus state and bus_gnt=1; that cycle
// has mem_sel=1, and its read data is sampled at the closing posedge. With
// bus_gnt=0 the engine freezes (no sample, no counter/address change).
module linear_layer_stream_mem
  import lin_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int W_WIDTH       = 8,
  parameter int ACC_WIDTH     = 32,
  parameter int OUT_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int DATABUS_WIDTH = 32,
  parameter int N_MAX         = 64,
  parameter int M_MAX         = 64,
  localparam int NW = $clog2(N_MAX + 1),
  localparam int MW = $clog2(M_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NW-1:0]         n_in,
  input  logic [MW-1:0]         m_out,
  input  logic [ADDR_WIDTH-1:0] activ_base,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [ADDR_WIDTH-1:0] bias_base,
  input  logic [ADDR_WIDTH-1:0] output_base,
  input  logic                  relu_en,
  input  logic [4:0]            shift,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic                  mem_sel,
  output logic                  mem_w,
  inout  wire [ADDR_WIDTH-1:0]  address_bus,
  inout  wire [DATABUS_WIDTH-1:0] data_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  sat_flag,
  output logic [2:0]            dbg_state
);

  localparam int PW = DATA_WIDTH + W_WIDTH;
  localparam int AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;

  state_t r_state;
  state_t w_next;

  logic [NW-1:0]         r_n, r_j;
  logic [MW-1:0]         r_m, r_i;
  logic [ADDR_WIDTH-1:0] r_activ_base, r_bias_base, r_output_base, r_waddr;
  logic                  r_relu, r_err, r_sat;
  logic [4:0]            r_shift;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [OUT_WIDTH-1:0]  r_res;
  logic signed [DATA_WIDTH-1:0] r_act [N_MAX];

  logic                     w_bad, w_last_j, w_last_i;
  logic [ADDR_WIDTH-1:0]    w_addr;
  logic [DATABUS_WIDTH-1:0] w_rdata, w_wdata;
  logic signed [PW-1:0]     w_prod;
  logic [OUT_WIDTH-1:0]     w_pp_res;
  logic                     w_pp_sat;

  assign w_bad    = (n_in == '0) || (n_in > NW'(N_MAX)) ||
                    (m_out == '0) || (m_out > MW'(M_MAX));
  assign w_last_j = (r_j == r_n - NW'(1));
  assign w_last_i = (r_i == r_m - MW'(1));
  assign w_rdata  = data_bus;
  assign w_prod   = r_act[r_j[AW-1:0]] * signed'(w_rdata[W_WIDTH-1:0]);
  assign w_wdata  = {{(DATABUS_WIDTH-OUT_WIDTH){r_res[OUT_WIDTH-1]}}, r_res};

  assign address_bus = mem_sel ? w_addr : 'z;
  assign data_bus    = (mem_sel && mem_w) ? w_wdata : 'z;

  assign sat_flag  = r_sat;
  assign dbg_state = r_state;

  lin_postproc #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_postproc (
    .i_acc     (r_acc),
    .i_relu_en (r_relu),
    .i_shift   (r_shift),
    .o_result  (w_pp_res),
    .o_sat     (w_pp_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and bus/status outputs, decoded from the current state.
  always_comb begin
    w_next  = r_state;
    bus_req = 1'b0;
    mem_sel = 1'b0;
    mem_w   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    w_addr  = '0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = w_bad ? DONE : REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) w_next = LOAD_ACT;
      end
      LOAD_ACT: begin
        bus_req = 1'b1;
        mem_sel = bus_gnt;
        w_addr  = r_activ_base + ADDR_WIDTH'(r_j);
        if (bus_gnt && w_last_j) w_next = BIAS;
      end
      BIAS: begin
        bus_req = 1'b1;
        mem_sel = bus_gnt;
        w_addr  = r_bias_base + ADDR_WIDTH'(r_i);
        if (bus_gnt) w_next = MAC;
      end
      MAC: begin
        bus_req = 1'b1;
        mem_sel = bus_gnt;
        w_addr  = r_waddr;
        if (bus_gnt && w_last_j) w_next = POST;
      end
      POST: begin
        bus_req = 1'b1;
        w_next  = WRITE;
      end
      WRITE: begin
        bus_req = 1'b1;
        mem_sel = bus_gnt;
        mem_w   = bus_gnt;
        w_addr  = r_output_base + ADDR_WIDTH'(r_i);
        if (bus_gnt) w_next = w_last_i ? DONE : BIAS;
      end
      DONE: begin
        busy   = 1'b0;
        done   = 1'b1;
        err    = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Layer configuration capture, counters, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n           <= '0;
      r_m           <= '0;
      r_j           <= '0;
      r_i           <= '0;
      r_activ_base  <= '0;
      r_bias_base   <= '0;
      r_output_base <= '0;
      r_waddr       <= '0;
      r_relu        <= 1'b0;
      r_shift       <= '0;
      r_err         <= 1'b0;
      r_sat         <= 1'b0;
      r_acc         <= '0;
      r_res         <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_n           <= n_in;
            r_m           <= m_out;
            r_j           <= '0;
            r_i           <= '0;
            r_activ_base  <= activ_base;
            r_bias_base   <= bias_base;
            r_output_base <= output_base;
            r_waddr       <= weight_base;
            r_relu        <= relu_en;
            r_shift       <= shift;
            r_err         <= w_bad;
            r_sat         <= 1'b0;
            r_acc         <= '0;
          end
        end
        LOAD_ACT: begin
          if (bus_gnt) r_j <= w_last_j ? '0 : r_j + NW'(1);
        end
        BIAS: begin
          if (bus_gnt) begin
            r_acc <= w_rdata[ACC_WIDTH-1:0];
            r_j   <= '0;
          end
        end
        MAC: begin
          if (bus_gnt) begin
            r_acc   <= r_acc + {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
            r_waddr <= r_waddr + ADDR_WIDTH'(1);
            r_j     <= w_last_j ? '0 : r_j + NW'(1);
          end
        end
        POST: begin
          r_res <= w_pp_res;
          r_sat <= r_sat | w_pp_sat;
        end
        WRITE: begin
          if (bus_gnt) r_i <= r_i + MW'(1);
        end
        default: ;
      endcase
    end
  end

  // Activation buffer fill; sign-extension happens through the signed element type.
  always_ff @(posedge clk) begin
    if (r_state == LOAD_ACT && bus_gnt)
      r_act[r_j[AW-1:0]] <= signed'(w_rdata[DATA_WIDTH-1:0]);
  end

endmodule
